// File: rtl/fir_pkg.sv
// Shared constants and FSM encoding for the pruned Q15 FIR, its sample feeder
// and the 2-D scan controller.
package fir_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  localparam int L         = 65;
  localparam int NZ        = 24;
  localparam int IN_W      = 16;
  localparam int FLUSH_LEN = L - 1;

endpackage

// File: rtl/fir_feed_fifo.sv
// Single-clock FIFO without fall-through: a word written into an empty FIFO
// becomes visible on rdata_o in the following cycle.
module fir_feed_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [AW:0]  count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fir_sample_feeder.sv
// Paces a buffered sample stream into a sequential FIR: one sample in flight,
// and FLUSH_LEN zeros after each end-of-row sample to clear the delay line.
module fir_sample_feeder #(
  parameter int IN_W       = fir_pkg::IN_W,
  parameter int FIFO_DEPTH = 8,
  parameter int FLUSH_LEN  = fir_pkg::FLUSH_LEN,
  parameter int TIMEOUT    = 63,
  parameter int CNT_W      = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IN_W-1:0] s_data,
  input  logic            s_valid,
  input  logic            s_last,
  output logic            s_ready,
  output logic [IN_W-1:0] fir_data,
  output logic            fir_valid,
  input  logic            fir_done,
  output logic            busy,
  output logic            row_done,
  output logic            timeout_err
);
  import fir_pkg::*;

  localparam int AW = $clog2(FIFO_DEPTH);

  logic            fifo_full, fifo_empty, fifo_pop;
  logic [AW:0]     fifo_count;
  logic [IN_W:0]   fifo_rdata;

  state_t          state_q;
  logic            outstanding_q, last_pending_q;
  logic [CNT_W-1:0] flush_cnt_q, tmo_cnt_q;
  logic [IN_W-1:0] fir_data_q;
  logic            fir_valid_q, row_done_q, timeout_err_q;

  logic done_evt, expire, cmpl, slot_free, flush_last, run_issue, flush_issue;

  fir_feed_fifo #(
    .W     (IN_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (s_valid),
    .wdata_i ({s_last, s_data}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Expiry is checked one count early so the error pulse lands TIMEOUT cycles
  // after the issue; a real completion on that cycle wins.
  always_comb begin
    done_evt    = outstanding_q && fir_done;
    expire      = outstanding_q && !fir_done && (tmo_cnt_q == CNT_W'(TIMEOUT - 1));
    cmpl        = done_evt || expire;
    slot_free   = (!outstanding_q || done_evt) && !fir_valid_q;
    flush_last  = (flush_cnt_q == CNT_W'(FLUSH_LEN));
    run_issue   = (state_q == ST_RUN) && !(cmpl && last_pending_q) && slot_free && !fifo_empty;
    flush_issue = (state_q == ST_FLUSH) && slot_free && !flush_last;
    fifo_pop    = run_issue;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_RUN;
      outstanding_q  <= 1'b0;
      last_pending_q <= 1'b0;
      flush_cnt_q    <= '0;
      tmo_cnt_q      <= '0;
      fir_data_q     <= '0;
      fir_valid_q    <= 1'b0;
      row_done_q     <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      fir_valid_q   <= 1'b0;
      row_done_q    <= 1'b0;
      timeout_err_q <= expire;

      if (run_issue || flush_issue) begin
        fir_valid_q    <= 1'b1;
        outstanding_q  <= 1'b1;
        tmo_cnt_q      <= '0;
        fir_data_q     <= run_issue ? fifo_rdata[IN_W-1:0] : '0;
        last_pending_q <= run_issue && fifo_rdata[IN_W];
        if (flush_issue) flush_cnt_q <= flush_cnt_q + 1'b1;
      end else if (cmpl) begin
        outstanding_q <= 1'b0;
      end else if (outstanding_q) begin
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end

      // Row boundaries: the completing cycle never issues, so the delay line
      // sees a clean separation between rows.
      case (state_q)
        ST_RUN: begin
          if (cmpl && last_pending_q) begin
            state_q        <= ST_FLUSH;
            flush_cnt_q    <= '0;
            last_pending_q <= 1'b0;
          end
        end
        ST_FLUSH: begin
          if (cmpl && flush_last) begin
            state_q    <= ST_RUN;
            row_done_q <= 1'b1;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign s_ready     = !fifo_full;
  assign fir_data    = fir_data_q;
  assign fir_valid   = fir_valid_q;
  assign row_done    = row_done_q;
  assign timeout_err = timeout_err_q;
  assign busy        = outstanding_q || (state_q == ST_FLUSH) || (fifo_count != '0);

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Directed bench for fir_sample_feeder: issue latency, pacing, full buffer,
// row flush, timeout and reset during a flush.
module tb_fir_sample_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic [15:0] fir_data;
  logic        fir_valid;
  logic        fir_done;
  logic        busy;
  logic        row_done;
  logic        timeout_err;

  logic resp_en = 1'b0;
  logic man_done = 1'b0;
  logic resp_done = 1'b0;
  int   resp_dly = 26;
  int   rcnt = 0;

  assign fir_done = resp_en ? resp_done : man_done;

  fir_sample_feeder dut (
    .clk         (clk),
    .rst         (rst),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .fir_data    (fir_data),
    .fir_valid   (fir_valid),
    .fir_done    (fir_done),
    .busy        (busy),
    .row_done    (row_done),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // FIR responder: fir_done exactly resp_dly cycles after each fir_valid.
  always @(negedge clk) begin
    if (!resp_en) begin
      rcnt      <= 0;
      resp_done <= 1'b0;
    end else if (fir_valid) begin
      rcnt      <= resp_dly;
      resp_done <= 1'b0;
    end else if (rcnt != 0) begin
      rcnt      <= rcnt - 1;
      resp_done <= (rcnt == 1);
    end else begin
      resp_done <= 1'b0;
    end
  end

  // Output monitor, sampled mid-cycle.
  logic [15:0] vq[$];
  int          vcyc[$];
  int          cyc = 0;
  int          consec = 0;
  logic        prev_v = 1'b0;
  int          rd_count = 0;
  int          rd_cyc = 0;
  int          rd_at = 0;
  int          te_count = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (fir_valid) begin
      vq.push_back(fir_data);
      vcyc.push_back(cyc);
    end
    if (fir_valid && prev_v) consec <= consec + 1;
    prev_v <= fir_valid;
    if (row_done) begin
      rd_count <= rd_count + 1;
      rd_cyc   <= cyc;
      rd_at    <= vq.size();
    end
    if (timeout_err) te_count <= te_count + 1;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [15:0] d, input logic l);
    s_data  = d;
    s_last  = l;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      tick();
      if (!busy && !fir_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  int b, idx, te0, v0, v1, rd0, nz;
  bit ok, acc;

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_valid", fir_valid, 1'b0);
    chk("rst_data", fir_data, 16'h0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", s_ready, 1'b1);
    chk("rst_pulses", {row_done, timeout_err}, 2'b00);
    rst = 1'b0;
    tick();

    // Basic issue: push cycle P, fir_valid in P+2
    s_data = 16'h1234; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    chk("basic_early", fir_valid, 1'b0);
    chk("basic_busy", busy, 1'b1);
    tick();
    chk("basic_valid", fir_valid, 1'b1);
    chk("basic_data", fir_data, 16'h1234);

    // Timeout: no fir_done; next buffered word waits behind the stuck sample
    s_data = 16'hBEEF; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    chk("basic_single", fir_valid, 1'b0);
    te0 = te_count; v0 = vq.size();
    repeat (61) tick();
    chk("tmo_quiet_err", te_count, te0);
    chk("tmo_quiet_valid", vq.size(), v0);
    tick();
    chk("tmo_err", timeout_err, 1'b1);
    chk("tmo_no_issue", fir_valid, 1'b0);
    tick();
    chk("tmo_next_valid", fir_valid, 1'b1);
    chk("tmo_next_data", fir_data, 16'hBEEF);
    chk("tmo_err_pulse", timeout_err, 1'b0);

    // fir_done on the expiry cycle wins over the timeout
    repeat (62) tick();
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    chk("tmo_tie_err", timeout_err, 1'b0);
    chk("tmo_tie_idle", busy, 1'b0);

    // Stray fir_done with nothing outstanding
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    tick();
    chk("stray_done", {busy, fir_valid, timeout_err}, 3'b000);

    // Back-to-back pacing with a 26-cycle FIR
    resp_dly = 26; resp_en = 1'b1; b = vq.size();
    s_valid = 1'b1;
    s_data = 16'h0001; tick();
    s_data = 16'h0002; tick();
    s_data = 16'h0003; tick();
    s_valid = 1'b0;
    wait_idle(300, ok);
    chk("pace_idle", ok, 1'b1);
    chk("pace_count", vq.size() - b, 3);
    chk("pace_d0", vq[b], 16'h0001);
    chk("pace_d1", vq[b+1], 16'h0002);
    chk("pace_d2", vq[b+2], 16'h0003);
    chk("pace_gap1", vcyc[b+1] - vcyc[b], 27);
    chk("pace_gap2", vcyc[b+2] - vcyc[b+1], 27);

    // Full FIFO: 8 buffered + 1 issued before s_ready falls
    resp_en = 1'b0; man_done = 1'b0; b = vq.size(); idx = 0;
    for (int i = 0; i < 12; i++) begin
      s_data  = 16'hA000 + 16'(idx);
      s_valid = 1'b1;
      acc     = s_ready;
      tick();
      if (acc) idx++;
    end
    chk("full_accepted", idx, 9);
    chk("full_ready", s_ready, 1'b0);
    man_done = 1'b1;
    tick();
    man_done = 1'b0; resp_dly = 3; resp_en = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      acc = s_ready;
      tick();
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    s_valid = 1'b0;
    chk("full_last_accepted", ok, 1'b1);
    wait_idle(400, ok);
    chk("full_idle", ok, 1'b1);
    chk("full_count", vq.size() - b, 10);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("full_order%0d", i), vq[b+i], 16'hA000 + 16'(i));
    end

    // Row flush: 64 zeros after the last sample, then row_done
    resp_dly = 4; b = vq.size(); rd0 = rd_count;
    push1(16'h7FFF, 1'b1);
    repeat (20) tick();
    chk("flush_busy", busy, 1'b1);
    chk("flush_no_rowdone", rd_count, rd0);
    push1(16'h0B01, 1'b0);
    push1(16'h0B02, 1'b0);
    wait_idle(1500, ok);
    chk("flush_idle", ok, 1'b1);
    chk("flush_total", vq.size() - b, 67);
    chk("flush_first", vq[b], 16'h7FFF);
    nz = 0;
    for (int i = 1; i <= 64; i++) begin
      if (vq[b+i] == 16'h0000) nz++;
    end
    chk("flush_zeros", nz, 64);
    chk("flush_rowdone_cnt", rd_count - rd0, 1);
    chk("flush_rowdone_pos", rd_at - b, 65);
    chk("flush_resume_d0", vq[b+65], 16'h0B01);
    chk("flush_resume_d1", vq[b+66], 16'h0B02);
    chk("flush_resume_gap", vcyc[b+65] - rd_cyc, 1);

    // Reset during flush sample 10
    b = vq.size(); rd0 = rd_count;
    push1(16'h1111, 1'b1);
    push1(16'h2222, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (vq.size() >= b + 11) begin
        ok = 1'b1;
        break;
      end
    end
    chk("mid_reached", ok, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", fir_valid, 1'b0);
    chk("mid_rst_ready", s_ready, 1'b1);
    chk("mid_rst_idle", busy, 1'b0);
    v1 = vq.size();
    repeat (100) tick();
    chk("mid_no_valid", vq.size(), v1);
    chk("mid_no_rowdone", rd_count, rd0);

    chk("no_consec_valid", consec, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fir_sample_feeder.md
Name: fir_sample_feeder

Overview:
- Transmit-side pacer for the sequential pruned Q15 FIR. It accepts an upstream ready/valid sample stream, buffers it, and drives the FIR's data_in/data_in_valid.
- It issues one sample, then holds off until the FIR's data_out_valid returns.
- After each end-of-row sample it injects FLUSH_LEN zero samples so the next row starts with a clean delay line.
- It sits between the row/column scan logic and each 1-D FIR instance of the 2-D filter.

Parameters:
- IN_W, 16, sample width (Q15 signed).
- FIFO_DEPTH, 8, input buffer entries; power of two, at least 2.
- FLUSH_LEN, 64, zero samples injected after s_last (FIR tap count minus 1).
- TIMEOUT, 63, maximum cycles to wait for fir_done before abandoning the sample.
- CNT_W, 7, width of the flush and timeout counters; must hold max(FLUSH_LEN, TIMEOUT).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- s_data  in  IN_W  upstream sample.
- s_valid  in  1  upstream sample valid.
- s_last  in  1  marks the last sample of a row; qualified by s_valid.
- s_ready  out  1  buffer can accept a sample this cycle.
- fir_data  out  IN_W  sample to the FIR data_in.
- fir_valid  out  1  single-cycle strobe to the FIR data_in_valid.
- fir_done  in  1  FIR data_out_valid; completion of the outstanding sample.
- busy  out  1  a sample is outstanding, or the FSM is in FLUSH, or the FIFO is non-empty.
- row_done  out  1  one-cycle pulse when the last flush sample completes.
- timeout_err  out  1  one-cycle pulse when the TIMEOUT counter expires.

Behaviour:
- **Reset.** rst is sampled on the clk edge. It clears:
  - FIFO pointers and count;
  - state to RUN, outstanding to 0, counters to 0;
  - fir_data, fir_valid, row_done and timeout_err to 0.
  - s_ready becomes 1 on the first cycle after reset deasserts.
  - Reset mid-operation discards any buffered or outstanding sample and any flush in progress. It issues no further fir_valid.
- **Input side.**
  - Push occurs when s_valid && s_ready.
  - s_ready = !full, with no combinational dependence on s_valid.
  - The FIFO stores {s_last, s_data}.
  - Push and pop in the same cycle are legal whenever the FIFO is not full.
  - The FIFO has no fall-through: a word pushed into an empty FIFO is poppable in the next cycle at the earliest.
- **Issue rule.** can_issue = !outstanding || fir_done. With fir_done high, the completion and a new issue may occur in the same cycle.
  - In RUN: if the FIFO is non-empty and can_issue, pop. Register fir_data to the popped data and pulse fir_valid for one cycle (registered, so it is visible next cycle). Set outstanding and set last_pending to the popped last bit.
  - fir_valid is never high on two consecutive cycles.
- **Completion.** fir_done with outstanding set clears outstanding, unless a new issue occurs in the same cycle.
  - Completing a sample that has last_pending set moves the FSM to FLUSH with flush_cnt = 0. That same cycle issues nothing from the FIFO.
  - fir_done while outstanding = 0 is ignored: no state change, no error.
- **FLUSH.** Issues zeros: fir_data = 0, fir_valid pulsed under the same can_issue rule, flush_cnt incremented per issue.
  - The FIFO is not popped during FLUSH.
  - Pushes continue while not full.
  - When the completion of the FLUSH_LEN-th zero arrives, row_done pulses for one cycle and the FSM returns to RUN.
  - FIFO issue may resume on the cycle after that completion.
- **Timeout.**
  - The timeout counter resets on every issue and increments while outstanding is set.
  - On reaching TIMEOUT without fir_done, it pulses timeout_err, clears outstanding, and continues as if the sample had completed, including FLUSH entry or advance.
  - A fir_done arriving in the same cycle as expiry takes precedence; timeout_err stays 0.
- **Latency.** A sample pushed into an empty, idle feeder appears on fir_valid 2 cycles after the push edge.
- **Throughput.** One sample per FIR completion, i.e. per (FIR compute time + 1) cycles. There is no bubble between fir_done and the next fir_valid beyond the 1-cycle register.
- **Wrap-around.** FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo the depth. Count is log2(FIFO_DEPTH)+1 bits.
- **Arithmetic.** Data is passed bit-exact; no arithmetic is performed on samples.

Decomposition:
- Shared package fir_pkg holds:
  - the FSM state encoding: ST_RUN = 1'b0, ST_FLUSH = 1'b1;
  - the FIR constants L = 65, NZ = 24 and IN_W = 16;
  - the derived value FLUSH_LEN = L-1, which is also used by the FIR and the 2-D scan controller.
- One sub-module, fir_feed_fifo: synchronous single-clock FIFO, width IN_W+1, with full/empty/count outputs and no fall-through.
- The pacing FSM, counters and output registers stay in fir_sample_feeder.

Test Plan:
- **Basic issue.** After reset, push 0x1234 (s_last = 0) and hold fir_done low. Required: fir_valid for exactly one cycle, 2 cycles after the push, with fir_data = 0x1234; busy = 1; no second fir_valid.
- **Back-to-back pacing.** Push 0x0001, 0x0002, 0x0003; the responder model returns fir_done 26 cycles after each fir_valid. Required: fir_valid on the cycle after each fir_done, data in order, no consecutive fir_valid cycles.
- **Full FIFO.** Push 10 words with fir_done held low. Required: s_ready falls after 8 buffered words plus 1 issued; no word is lost or reordered once completions resume.
- **Row flush.** Push 0x7FFF with s_last = 1 and model FIR completions. Required: after its completion, exactly 64 fir_valid pulses with fir_data = 0x0000, then one row_done pulse. Words pushed during the flush are issued only after row_done.
- **Timeout.** Issue a sample and never assert fir_done. Required: timeout_err pulses 63 cycles later and the next buffered sample issues the cycle after. With fir_done on the expiry cycle, timeout_err stays 0.
- **Reset mid-flush.** Assert rst at flush sample 10. Required: fir_valid = 0 from the next cycle, the FIFO is empty, s_ready = 1, row_done is never pulsed.
